gcd_entry_driver: RTL and testbench

Autonomous front-panel driver for the two-digit GCD entry unit: it turns a single "load digits A and B" command into the button sequence the entry unit expects, namely `select`, `data_in` and debounced-width `add` / `next` pulses. It shares `clk` and `rst_n` with the entry unit and keeps shadow copies of the unit's two digit buffers and its mode. From those shadows it computes the mod-10 increments needed and presses only what is necessary. It sits between the test/host controller and the entry unit, replacing the physical buttons.

---
 rtl/gcd_panel_pkg.sv | 32 +++
 rtl/gcd_entry_driver_press_timer.sv | 51 +++++
 rtl/gcd_entry_driver.sv | 144 ++++++++++++++
 tb/tb_gcd_entry_driver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_panel_pkg.sv
// Shared types and helpers for the GCD front-panel driver.
// States, press phases, digit limits and mod-10 subtract.
package gcd_panel_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    LEAVE,
    ADD_A,
    ADD_B,
    ENTER
  } state_t;

  typedef enum logic {
    PRESS,
    GAP
  } phase_t;

  // (t - s) mod 10 for BCD digits, widened to 5 bits first
  function automatic logic [DIGIT_W-1:0] sub_mod10(
    input logic [DIGIT_W-1:0] t,
    input logic [DIGIT_W-1:0] s
  );
    logic [DIGIT_W:0] r;
    if (t >= s) r = {1'b0, t} - {1'b0, s};
    else        r = {1'b0, t} + 5'd10 - {1'b0, s};
    return r[DIGIT_W-1:0];
  endfunction

endpackage

// File: rtl/gcd_entry_driver_press_timer.sv
// Press/gap timer: go starts PULSE_LEN press cycles then GAP_LEN gap cycles.
// Ports: clk, rst_n, go -> pressing, press_end, gap_end.
module press_timer
  import gcd_panel_pkg::*;
#(
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  output logic pressing,
  output logic press_end,
  output logic gap_end
);

  localparam int CNT_MAX =
    (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_LEN - 1);

  logic          active;
  phase_t        phase;
  logic [CW-1:0] cnt;

  assign pressing  = active && (phase == PRESS);
  assign press_end = pressing && (cnt == P_LAST);
  assign gap_end   = active && (phase == GAP) &&
                     (cnt == G_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active <= 1'b0;
      phase  <= PRESS;
      cnt    <= '0;
    end else if (go) begin
      active <= 1'b1;
      phase  <= PRESS;
      cnt    <= '0;
    end else if (press_end) begin
      phase <= GAP;
      cnt   <= '0;
    end else if (gap_end) begin
      active <= 1'b0;
    end else if (active) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/gcd_entry_driver.sv
// Front-panel driver: turns load/toggle requests into add/next presses.
// Ports: clk, rst_n, start, digit_a/b, toggle -> select, add, next, data_in, busy, done, err, gcd_mode.
module gcd_entry_driver
  import gcd_panel_pkg::*;
#(
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DIGIT_W-1:0] digit_a,
  input  logic [DIGIT_W-1:0] digit_b,
  input  logic               toggle,
  output logic               select,
  output logic               add,
  output logic               next,
  output logic [DIGIT_W-1:0] data_in,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               gcd_mode
);

  state_t state, state_d;
  logic need_a, need_b, need_a_d, need_b_d;
  logic [DIGIT_W-1:0] tgt_a, tgt_b, sh_a, sh_b;
  logic [DIGIT_W-1:0] op_a, op_b;
  logic go, pressing, press_end, gap_end;
  logic bad, load, press_d;

  press_timer #(
    .PULSE_LEN(PULSE_LEN),
    .GAP_LEN  (GAP_LEN)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .pressing (pressing),
    .press_end(press_end),
    .gap_end  (gap_end)
  );

  assign bad  = (digit_a > DIGIT_MAX) ||
                (digit_b > DIGIT_MAX);
  assign load = (state == IDLE) && start && !bad;
  // targets are not latched yet on the accepting edge
  assign op_a = (state == IDLE) ? digit_a : tgt_a;
  assign op_b = (state == IDLE) ? digit_b : tgt_b;

  always_comb begin
    state_d  = state;
    need_a_d = need_a;
    need_b_d = need_b;
    go       = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          need_a_d = (digit_a != sh_a);
          need_b_d = (digit_b != sh_b);
          go       = 1'b1;
          if (gcd_mode)      state_d = LEAVE;
          else if (need_a_d) state_d = ADD_A;
          else if (need_b_d) state_d = ADD_B;
          else               state_d = ENTER;
        end else if (toggle && !start) begin
          // a lone mode flip is just an ENTER press
          need_a_d = 1'b0;
          need_b_d = 1'b0;
          go       = 1'b1;
          state_d  = ENTER;
        end
      end
      LEAVE: if (gap_end) begin
        if (need_a)      state_d = ADD_A;
        else if (need_b) state_d = ADD_B;
        else             state_d = ENTER;
      end
      ADD_A: if (gap_end)
        state_d = need_b ? ADD_B : ENTER;
      ADD_B: if (gap_end) state_d = ENTER;
      ENTER: if (gap_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state != IDLE && gap_end &&
        state_d != IDLE)
      go = 1'b1;
  end

  assign press_d = go || (pressing && !press_end);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      need_a   <= 1'b0;
      need_b   <= 1'b0;
      tgt_a    <= '0;
      tgt_b    <= '0;
      sh_a     <= '0;
      sh_b     <= '0;
      select   <= 1'b0;
      add      <= 1'b0;
      next     <= 1'b0;
      data_in  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      gcd_mode <= 1'b0;
    end else begin
      state  <= state_d;
      need_a <= need_a_d;
      need_b <= need_b_d;
      if (load) begin
        tgt_a <= digit_a;
        tgt_b <= digit_b;
      end
      add  <= press_d &&
              (state_d == ADD_A || state_d == ADD_B);
      next <= press_d &&
              (state_d == LEAVE || state_d == ENTER);
      busy <= (state_d != IDLE);
      done <= (state != IDLE) && (state_d == IDLE);
      err  <= (state == IDLE) && start && bad;
      // operand held from press start through its gap
      if (go && state_d == ADD_A) begin
        select  <= 1'b0;
        data_in <= sub_mod10(op_a, sh_a);
      end
      if (go && state_d == ADD_B) begin
        select  <= 1'b1;
        data_in <= sub_mod10(op_b, sh_b);
      end
      if (press_end) begin
        unique case (state)
          ADD_A:        sh_a     <= tgt_a;
          ADD_B:        sh_b     <= tgt_b;
          LEAVE, ENTER: gcd_mode <= ~gcd_mode;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gcd_entry_driver.sv
// Self-checking bench for gcd_entry_driver.
// Expected presses are queued before each request and popped on press edges.
module tb_gcd_entry_driver;

  typedef struct {
    bit         is_add;
    logic       sel;
    logic [3:0] d;
  } press_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       toggle = 1'b0;
  logic [3:0] digit_a = '0;
  logic [3:0] digit_b = '0;
  logic       select, add, next, busy, done, err, gcd_mode;
  logic [3:0] data_in;

  int total = 0;
  int bad = 0;
  int run = 0;
  int last_len = 0;
  int ndone = 0;
  logic prev_add = 1'b0;
  logic prev_next = 1'b0;
  press_t q[$];

  always #5 clk = ~clk;

  gcd_entry_driver #(.PULSE_LEN(2), .GAP_LEN(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .digit_a (digit_a),
    .digit_b (digit_b),
    .toggle  (toggle),
    .select  (select),
    .add     (add),
    .next    (next),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .gcd_mode(gcd_mode)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic push(input bit a, input logic s,
                      input logic [3:0] d);
    press_t e;
    e.is_add = a;
    e.sel = s;
    e.d = d;
    q.push_back(e);
  endtask

  // scoreboard / busy-length monitor
  always @(negedge clk) begin
    press_t e;
    if (!rst_n) begin
      run = 0;
    end else begin
      if (add || next)
        chk("add_next_excl", 32'(add & next), 0);
      if ((add && !prev_add) || (next && !prev_next)) begin
        if (q.size() == 0) begin
          chk("press_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          chk("press_kind", 32'(add), 32'(e.is_add));
          if (e.is_add) begin
            chk("press_select", 32'(select), 32'(e.sel));
            chk("press_data", 32'(data_in), 32'(e.d));
          end
        end
      end
      if (busy) run++;
      if (done) begin
        last_len = run;
        run = 0;
        ndone++;
      end
    end
    prev_add = add;
    prev_next = next;
  end

  task automatic req(input logic s, input logic t,
                     input logic [3:0] a,
                     input logic [3:0] b);
    @(posedge clk); #2;
    start = s;
    toggle = t;
    digit_a = a;
    digit_b = b;
    @(posedge clk); #2;
    start = 1'b0;
    toggle = 1'b0;
  endtask

  task automatic wait_done(input string tag,
                           input int exp_len);
    int d0;
    bit got;
    d0 = ndone;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (ndone != d0) begin
        got = 1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(got), 1);
    chk({tag, "_busy_len"}, 32'(last_len), 32'(exp_len));
    chk({tag, "_queue_empty"}, 32'(q.size()), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        32'({select, add, next, data_in,
             busy, done, err, gcd_mode}), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // 1: load 7/3 from reset
    push(1, 0, 4'd7);
    push(1, 1, 4'd3);
    push(0, 0, 4'd0);
    req(1, 0, 4'd7, 4'd3);
    @(negedge clk);
    chk("t1_busy_k1", 32'(busy), 1);
    chk("t1_add_k1", 32'(add), 1);
    wait_done("t1", 12);
    chk("t1_mode", 32'(gcd_mode), 1);

    // 2: reload from gcd mode, B unchanged
    push(0, 0, 4'd0);
    push(1, 0, 4'd5);
    push(0, 0, 4'd0);
    req(1, 0, 4'd2, 4'd3);
    wait_done("t2", 12);
    chk("t2_mode", 32'(gcd_mode), 1);

    // 3: invalid digit
    req(1, 0, 4'd10, 4'd4);
    @(negedge clk);
    chk("t3_err", 32'(err), 1);
    chk("t3_busy", 32'(busy), 0);
    @(negedge clk);
    chk("t3_err_pulse", 32'(err), 0);
    repeat (4) @(negedge clk);
    chk("t3_idle", 32'({add, next, busy}), 0);

    // 4: requests while busy are ignored (shadow A still 2)
    push(0, 0, 4'd0);
    push(1, 0, 4'd3);
    push(0, 0, 4'd0);
    req(1, 0, 4'd5, 4'd3);
    repeat (3) @(posedge clk);
    #2;
    start = 1'b1;
    toggle = 1'b1;
    digit_a = 4'd9;
    digit_b = 4'd9;
    @(posedge clk); #2;
    start = 1'b0;
    toggle = 1'b0;
    wait_done("t4", 12);
    chk("t4_mode", 32'(gcd_mode), 1);

    // 5a: toggle alone
    push(0, 0, 4'd0);
    req(0, 1, 4'd0, 4'd0);
    wait_done("t5a", 4);
    chk("t5a_mode", 32'(gcd_mode), 0);

    // 5b: start wins over toggle
    push(1, 0, 4'd6);
    push(1, 1, 4'd5);
    push(0, 0, 4'd0);
    req(1, 1, 4'd1, 4'd8);
    wait_done("t5b", 12);
    chk("t5b_mode", 32'(gcd_mode), 1);

    // 6: reset during ADD_B press
    push(0, 0, 4'd0);
    push(1, 0, 4'd6);
    push(1, 1, 4'd5);
    req(1, 0, 4'd7, 4'd3);
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk); #1;
        if (add && select) begin
          hit = 1;
          break;
        end
      end
      chk("t6_addb_seen", 32'(hit), 1);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_add", 32'(add), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_mode", 32'(gcd_mode), 0);
    q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    push(1, 0, 4'd7);
    push(1, 1, 4'd3);
    push(0, 0, 4'd0);
    req(1, 0, 4'd7, 4'd3);
    wait_done("t6", 12);
    chk("t6_mode", 32'(gcd_mode), 1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
